// File: rtl/add_arbiter_if.sv
// Requester, wide-adder and response handshakes of the add arbiter.
// master = arbiter side, slave = requesters/adder/consumer side.
interface add_arbiter_if #(
  parameter int N = 4096
);
  logic         req0_vld;
  logic         req0_rdy;
  logic [N:0]   req0_a;
  logic [N:0]   req0_b;
  logic [2:0]   req0_ctl;
  logic         req1_vld;
  logic         req1_rdy;
  logic [N:0]   req1_a;
  logic [N:0]   req1_b;
  logic [2:0]   req1_ctl;
  logic         add_vld;
  logic [N:0]   add_a;
  logic [N:0]   add_b;
  logic [2:0]   add_ctl;
  logic [N+2:0] add_sum;
  logic         add_cout;
  logic         add_done;
  logic         rsp_vld;
  logic         rsp_rdy;
  logic         rsp_id;
  logic [N+2:0] rsp_sum;
  logic         rsp_cout;
  logic         err_timeout;

  modport master (
    input  req0_vld, req0_a, req0_b, req0_ctl,
    output req0_rdy,
    input  req1_vld, req1_a, req1_b, req1_ctl,
    output req1_rdy,
    output add_vld, add_a, add_b, add_ctl,
    input  add_sum, add_cout, add_done,
    output rsp_vld, rsp_id, rsp_sum, rsp_cout,
    input  rsp_rdy,
    output err_timeout
  );

  modport slave (
    output req0_vld, req0_a, req0_b, req0_ctl,
    input  req0_rdy,
    output req1_vld, req1_a, req1_b, req1_ctl,
    input  req1_rdy,
    input  add_vld, add_a, add_b, add_ctl,
    output add_sum, add_cout, add_done,
    input  rsp_vld, rsp_id, rsp_sum, rsp_cout,
    output rsp_rdy,
    input  err_timeout
  );
endinterface

// File: rtl/add_arbiter.sv
// Two-requester round-robin front end for a multi-cycle wide adder, one op in flight.
// Latency: adder latency + 3 cycles to rsp_vld; rsp held until rsp_rdy, requesters stalled meanwhile.
module add_arbiter #(
  parameter int N       = 4096,
  parameter int TIMEOUT = 64
) (
  input logic            clk,
  input logic            rst_n,
  add_arbiter_if.master  bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          last;
  logic          gnt_id;
  logic          pick1;

  // req1 wins only when alone or when req0 was served last
  assign pick1 = bus.req1_vld && (!bus.req0_vld || !last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      last            <= 1'b1;
      gnt_id          <= 1'b0;
      bus.req0_rdy    <= 1'b0;
      bus.req1_rdy    <= 1'b0;
      bus.add_vld     <= 1'b0;
      bus.add_a       <= '0;
      bus.add_b       <= '0;
      bus.add_ctl     <= '0;
      bus.rsp_vld     <= 1'b0;
      bus.rsp_id      <= 1'b0;
      bus.rsp_sum     <= '0;
      bus.rsp_cout    <= 1'b0;
      bus.err_timeout <= 1'b0;
    end else begin
      bus.req0_rdy <= 1'b0;
      bus.req1_rdy <= 1'b0;
      bus.add_vld  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req0_vld || bus.req1_vld) begin
            gnt_id       <= pick1;
            last         <= pick1;
            bus.req0_rdy <= !pick1;
            bus.req1_rdy <= pick1;
            bus.add_a    <= pick1 ? bus.req1_a   : bus.req0_a;
            bus.add_b    <= pick1 ? bus.req1_b   : bus.req0_b;
            bus.add_ctl  <= pick1 ? bus.req1_ctl : bus.req0_ctl;
            bus.add_vld  <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // a done arriving on the final count still wins over the timeout
          if (bus.add_done) begin
            bus.rsp_sum  <= bus.add_sum;
            bus.rsp_cout <= bus.add_cout;
            bus.rsp_vld  <= 1'b1;
            bus.rsp_id   <= gnt_id;
            state        <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            bus.err_timeout <= 1'b1;
            bus.rsp_sum     <= '0;
            bus.rsp_cout    <= 1'b0;
            bus.rsp_vld     <= 1'b1;
            bus.rsp_id      <= gnt_id;
            state           <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_rdy) begin
            bus.rsp_vld <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 SHALL have parameter N, default 4096: operand width; operands are N+1 bits, sum is N+3 bits.
REQ-002 SHALL have parameter TIMEOUT, default 64: max cycles from adder issue to adder result.
REQ-003 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req0_vld  in  1  requester 0 has an operation pending.
REQ-006 SHALL have port req0_rdy  out  1  requester 0 accepted this cycle.
REQ-007 SHALL have port req0_a  in  N+1  requester 0 operand A.
REQ-008 SHALL have port req0_b  in  N+1  requester 0 operand B.
REQ-009 SHALL have port req0_ctl  in  3  {sign_in, cin, mode}; mode 1 = add, 0 = subtract.
REQ-010 SHALL have ports req1_vld, req1_rdy, req1_a, req1_b, req1_ctl, identical to requester 0.
REQ-011 SHALL have port add_vld  out  1  single-cycle start pulse to the wide adder.
REQ-012 SHALL have port add_a  out  N+1  latched operand A to the adder.
REQ-013 SHALL have port add_b  out  N+1  latched operand B to the adder.
REQ-014 SHALL have port add_ctl  out  3  latched {sign_in, cin, mode} to the adder.
REQ-015 SHALL have port add_sum  in  N+3  adder result.
REQ-016 SHALL have port add_cout  in  1  adder carry/borrow out.
REQ-017 SHALL have port add_done  in  1  adder result-valid pulse.
REQ-018 SHALL have port rsp_vld  out  1  response valid.
REQ-019 SHALL have port rsp_rdy  in  1  consumer accepts response.
REQ-020 SHALL have port rsp_id  out  1  index of the requester that owns the response.
REQ-021 SHALL have port rsp_sum  out  N+3  captured result; rsp_cout out 1 captured carry.
REQ-022 SHALL have port err_timeout  out  1  sticky timeout flag.

Function
REQ-023 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE, with a single operation in flight.
REQ-024 IDLE: if any reqX_vld, SHALL grant one, pulse its reqX_rdy for 1 cycle, latch a/b/ctl into add_*, and go to ISSUE.
REQ-025 Arbitration SHALL be round-robin: with both valid, grant the requester not granted last; pointer resets to "last = 1" (req0 wins first tie).
REQ-026 ISSUE: add_vld=1 for exactly one cycle, then WAIT; timeout counter cleared.
REQ-027 add_a/add_b/add_ctl SHALL stay stable from ISSUE until leaving WAIT (the adder samples slices over many cycles).
REQ-028 WAIT: on add_done, capture add_sum/add_cout into rsp_sum/rsp_cout and go to RESP; add_done outside WAIT SHALL be ignored.
REQ-029 WAIT: counter increments each cycle; reaching TIMEOUT without add_done SHALL set err_timeout, set rsp_sum=0, rsp_cout=0, and go to RESP.
REQ-030 RESP: rsp_vld=1 and rsp_id=granted index, held until rsp_rdy; on rsp_vld&&rsp_rdy go to IDLE.
REQ-031 reqX_rdy SHALL be 0 in all states except the IDLE grant cycle; new requests wait, no queueing.
REQ-032 err_timeout SHALL be cleared only by reset.
REQ-033 Minimum turnaround: request to rsp_vld = adder latency + 3 cycles; back-to-back ops SHALL have one IDLE cycle between them.

Reset
REQ-034 Asserting rst_n low at any time SHALL immediately force IDLE and zero every output, the counter and the captured data, and set the RR pointer to 1; an in-flight op is discarded.
REQ-035 After release, the first cycle SHALL behave as IDLE.

Verification
REQ-036 Single add: req0 a=5, b=3, ctl=3'b011, stub done after 34 cycles with sum=9 -> one add_vld pulse, rsp_id=0, rsp_sum=9.
REQ-037 Contention: req0 and req1 held valid for 4 ops -> grant order 0,1,0,1; each rdy a single pulse.
REQ-038 Stall: hold rsp_rdy=0 for 10 cycles -> rsp_vld and rsp_sum held, no req*_rdy issued.
REQ-039 Timeout: TIMEOUT=8, stub never asserts done -> err_timeout=1 at WAIT cycle 8, rsp_sum=0, FSM returns to IDLE after rsp_rdy.
REQ-040 Reset mid-WAIT: pull rst_n low -> all outputs 0 that cycle; late add_done after release is ignored; next req0 is served normally.
